// File: rtl/load_count_regbank.sv
// Four-entry register bank written from the packed load/count mux word, with a
// single down-counter that runs on any selected register and flags terminal count.
module load_count_regbank #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W+SEL_W-1:0]   load_word,
  input  logic                      load_en,
  input  logic                      start,
  input  logic [SEL_W-1:0]          count_sel,
  input  logic                      abort,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [DATA_W-1:0]         rd_data,
  output logic [DATA_W*(2**SEL_W)-1:0] regs_flat,
  output logic                      busy,
  output logic                      tc,
  output logic                      load_err
);

  localparam int NREGS = 2**SEL_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [SEL_W-1:0]  cs;
  logic [DATA_W-1:0] regs [NREGS];

  logic [DATA_W-1:0] load_data;
  logic [SEL_W-1:0]  load_sel;
  logic              load_blocked;

  assign load_data    = load_word[DATA_W+SEL_W-1:SEL_W];
  assign load_sel     = load_word[SEL_W-1:0];
  assign load_blocked = (state == COUNT) && (load_sel == cs);

  // The IDLE->COUNT/DONE decision reads regs[] before any same-edge load lands,
  // so a simultaneous load+start uses the old value to pick the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cs       <= '0;
      load_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      load_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            cs    <= count_sel;
            state <= (regs[count_sel] != '0) ? COUNT : DONE;
          end
        end
        COUNT: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (regs[cs] != '0) regs[cs] <= regs[cs] - DATA_W'(1);
            if (regs[cs] <= DATA_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A load aimed at the register being counted is refused; others always land.
      if (load_en) begin
        if (load_blocked) load_err <= 1'b1;
        else              regs[load_sel] <= load_data;
      end
    end
  end

  assign busy    = (state == COUNT);
  assign tc      = (state == DONE);
  assign rd_data = regs[rd_sel];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_load_count_regbank.sv
// Directed bench for load_count_regbank: expectations are queued as each step is
// driven and popped for comparison one cycle later, after the clock edge.
module tb_load_count_regbank;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  load_word;
  logic        load_en;
  logic        start;
  logic [1:0]  count_sel;
  logic        abort;
  logic [1:0]  rd_sel;
  logic [3:0]  rd_data;
  logic [15:0] regs_flat;
  logic        busy;
  logic        tc;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] flat;
    logic        busy;
    logic        tc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  load_count_regbank dut (
    .clk       (clk),
    .reset     (reset),
    .load_word (load_word),
    .load_en   (load_en),
    .start     (start),
    .count_sel (count_sel),
    .abort     (abort),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .regs_flat (regs_flat),
    .busy      (busy),
    .tc        (tc),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic rst, input logic ld, input logic [3:0] d,
                                input logic [1:0] sel, input logic st,
                                input logic [1:0] csel, input logic ab);
    reset     = rst;
    load_en   = ld;
    load_word = {d, sel};
    start     = st;
    count_sel = csel;
    abort     = ab;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_output();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (regs_flat === e.flat) else begin
      failures++;
      $error("[TB] FAIL %s regs_flat: got %h want %h", e.tag, regs_flat, e.flat);
    end
    checks++;
    assert (busy === e.busy) else begin
      failures++;
      $error("[TB] FAIL %s busy: got %b want %b", e.tag, busy, e.busy);
    end
    checks++;
    assert (tc === e.tc) else begin
      failures++;
      $error("[TB] FAIL %s tc: got %b want %b", e.tag, tc, e.tc);
    end
    checks++;
    assert (load_err === e.err) else begin
      failures++;
      $error("[TB] FAIL %s load_err: got %b want %b", e.tag, load_err, e.err);
    end
  endtask

  // Queue the expectation for the upcoming edge, clock it, then compare.
  task automatic tick(input string tag, input logic [15:0] flat,
                      input logic b, input logic t, input logic er);
    exp_t e;
    e.tag = tag; e.flat = flat; e.busy = b; e.tc = t; e.err = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic check_rd(input string tag, input logic [1:0] sel, input logic [3:0] want);
    rd_sel = sel;
    #1;
    checks++;
    assert (rd_data === want) else begin
      failures++;
      $error("[TB] FAIL %s rd_data: got %h want %h", tag, rd_data, want);
    end
  endtask

  initial begin
    rd_sel = 2'd0;
    apply_stimulus(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b0);
    tick("reset", 16'h0000, 0, 0, 0);

    // Plain load into reg2
    apply_stimulus(1'b0, 1'b1, 4'hA, 2'd2, 1'b0, 2'd0, 1'b0);
    tick("load_r2", 16'h0A00, 0, 0, 0);
    idle_inputs();
    check_rd("rd_r2", 2'd2, 4'hA);

    // Count reg1 from 3
    apply_stimulus(1'b0, 1'b1, 4'h3, 2'd1, 1'b0, 2'd0, 1'b0);
    tick("load_r1", 16'h0A30, 0, 0, 0);
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 2'd1, 1'b0);
    tick("cnt_start", 16'h0A30, 1, 0, 0);
    idle_inputs();
    tick("cnt_2", 16'h0A20, 1, 0, 0);
    tick("cnt_1", 16'h0A10, 1, 0, 0);
    tick("cnt_0", 16'h0A00, 0, 1, 0);
    // start presented in DONE must be ignored
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 2'd2, 1'b0);
    tick("done_start", 16'h0A00, 0, 0, 0);
    idle_inputs();
    tick("after_done", 16'h0A00, 0, 0, 0);

    // Start on a zero register goes straight to DONE
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 2'd0, 1'b0);
    tick("zero_start", 16'h0A00, 0, 1, 0);
    idle_inputs();
    tick("zero_after", 16'h0A00, 0, 0, 0);

    // Collision load on the counting register, plus a load elsewhere
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 2'd2, 1'b0);
    tick("r2_start", 16'h0A00, 1, 0, 0);
    apply_stimulus(1'b0, 1'b1, 4'hF, 2'd2, 1'b0, 2'd0, 1'b0);
    tick("collide", 16'h0900, 1, 0, 1);
    apply_stimulus(1'b0, 1'b1, 4'h5, 2'd3, 1'b0, 2'd0, 1'b0);
    tick("load_r3", 16'h5800, 1, 0, 0);
    idle_inputs();
    check_rd("rd_r3", 2'd3, 4'h5);
    for (int v = 7; v >= 1; v--) tick("r2_cnt", {4'h5, 4'(v), 8'h00}, 1, 0, 0);
    tick("r2_zero", 16'h5000, 0, 1, 0);
    // Load to cs while in DONE is accepted
    apply_stimulus(1'b0, 1'b1, 4'hC, 2'd2, 1'b0, 2'd0, 1'b0);
    tick("done_load", 16'h5C00, 0, 0, 0);

    // Abort after four decrements
    apply_stimulus(1'b0, 1'b1, 4'h9, 2'd0, 1'b0, 2'd0, 1'b0);
    tick("load_r0", 16'h5C09, 0, 0, 0);
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 2'd0, 1'b0);
    tick("r0_start", 16'h5C09, 1, 0, 0);
    idle_inputs();
    for (int v = 8; v >= 5; v--) tick("r0_cnt", {12'h5C0, 4'(v)}, 1, 0, 0);
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b1);
    tick("abort", 16'h5C05, 0, 0, 0);
    idle_inputs();
    tick("abort_after", 16'h5C05, 0, 0, 0);

    // Reset in the middle of a count
    apply_stimulus(1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 2'd0, 1'b0);
    tick("r0_restart", 16'h5C05, 1, 0, 0);
    idle_inputs();
    tick("r0_dec", 16'h5C04, 1, 0, 0);
    apply_stimulus(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0, 1'b0);
    tick("mid_reset", 16'h0000, 0, 0, 0);
    idle_inputs();
    tick("reset_after", 16'h0000, 0, 0, 0);

    // Same-edge load and start: old value 2 picks COUNT, count runs from 7
    apply_stimulus(1'b0, 1'b1, 4'h2, 2'd1, 1'b0, 2'd0, 1'b0);
    tick("load_r1_2", 16'h0020, 0, 0, 0);
    apply_stimulus(1'b0, 1'b1, 4'h7, 2'd1, 1'b1, 2'd1, 1'b0);
    tick("same_edge", 16'h0070, 1, 0, 0);
    idle_inputs();
    for (int v = 6; v >= 1; v--) tick("r1_cnt", {8'h00, 4'(v), 4'h0}, 1, 0, 0);
    tick("r1_zero", 16'h0000, 0, 1, 0);
    tick("r1_after", 16'h0000, 0, 0, 0);

    // Same-edge with old value 0: straight to DONE while the load lands
    apply_stimulus(1'b0, 1'b1, 4'h3, 2'd0, 1'b1, 2'd0, 1'b0);
    tick("same_edge_zero", 16'h0003, 0, 1, 0);
    idle_inputs();
    tick("same_zero_after", 16'h0003, 0, 0, 0);
    check_rd("rd_r0", 2'd0, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
